// File: rtl/peak_meter.sv
// peak_meter: absolute peak-level meter with peak hold, stepped decay,
//   8-segment thermometer bar and optional sticky clip indicator.
// Latency: 1 cycle from a sample on meterIn to peak/bar/clip.
// Backpressure: none; one sample is consumed every clk_48 edge, and the
//   meter only observes the audio path.
//
// Ports:
//   clk_48  in   48 kHz sample clock, one sample per rising edge
//   reset   in   asynchronous, active-high
//   clear   in   synchronous clear of peak, state, counters and clip
//   meterIn in   16-bit signed audio sample (mute stage output)
//   peak    out  16-bit held/decaying peak magnitude, 0..32768
//   bar     out  8-bit thermometer display, bar[i] = peak >= 2^(8+i)
//   clip    out  clip indicator
//
// Build option: define PEAK_METER_CLIP_EN to build the clip detector and
// drive bar[7] from clip. Without it, clip is tied low, bar[7] shows
// peak >= 32768 and CLIP_LEVEL/CLIP_HOLD have no effect.

module peak_meter #(
  parameter int unsigned HOLD_SAMPLES = 24000, // 1..65535
  parameter int unsigned DECAY_DIV    = 48,    // 1..65535
  parameter int unsigned DECAY_SHIFT  = 4,     // 1..15
  parameter int unsigned CLIP_LEVEL   = 32767,
  parameter int unsigned CLIP_HOLD    = 48000
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic               clear,
  input  logic signed [15:0] meterIn,
  output logic        [15:0] peak,
  output logic        [7:0]  bar,
  output logic               clip
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LD  = 16'(HOLD_SAMPLES);
  localparam logic [15:0] DIV_LAST = 16'(DECAY_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  bar_q, bar_d;

  logic [16:0] mag;
  logic        capture;
  logic [15:0] step;

  // 17-bit magnitude: sign-extend then negate modulo 2^17, so -32768
  // becomes 32768 instead of wrapping back to a negative value.
  always_comb begin
    if (meterIn[15]) begin
      mag = 17'd0 - {1'b1, meterIn};
    end else begin
      mag = {1'b0, meterIn};
    end
  end

  // A zero sample never captures, so a muted input lets the peak decay.
  assign capture = (mag != 17'd0) && (mag >= {1'b0, peak_q});

  // Always at least 1 so small peaks still reach zero.
  assign step = (peak_q >> DECAY_SHIFT) | 16'd1;

  // ---------------------------------------------------------------------
  // Peak state machine next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;

    if (clear) begin
      state_d    = ST_IDLE;
      peak_d     = 16'd0;
      hold_cnt_d = 16'd0;
      div_cnt_d  = 16'd0;
    end else if (capture) begin
      // Capture wins over both the hold countdown and a decay step.
      state_d    = ST_HOLD;
      peak_d     = mag[15:0];
      hold_cnt_d = HOLD_LD;
      div_cnt_d  = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          peak_d = 16'd0;
        end
        ST_HOLD: begin
          hold_cnt_d = hold_cnt_q - 16'd1;
          if (hold_cnt_q == 16'd1) begin
            state_d   = ST_DECAY;
            div_cnt_d = 16'd0;
          end
        end
        ST_DECAY: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 16'd0;
            if (step >= peak_q) begin
              peak_d  = 16'd0;
              state_d = ST_IDLE;
            end else begin
              peak_d = peak_q - step;
            end
          end else begin
            div_cnt_d = div_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          peak_d     = 16'd0;
          hold_cnt_d = 16'd0;
          div_cnt_d  = 16'd0;
        end
      endcase
    end
  end

`ifdef PEAK_METER_CLIP_EN
  // ---------------------------------------------------------------------
  // Clip detector: flag stays up through CLIP_HOLD further non-clip
  // cycles after the counter is reloaded, then drops.
  // ---------------------------------------------------------------------
  localparam int CLIP_CW = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD + 1) : 1;
  localparam logic [CLIP_CW-1:0] CLIP_LD = CLIP_CW'(CLIP_HOLD);

  logic               clip_q, clip_d;
  logic [CLIP_CW-1:0] clip_cnt_q, clip_cnt_d;
  logic               clip_hit;

  assign clip_hit = (mag >= 17'(CLIP_LEVEL));

  always_comb begin
    clip_d     = clip_q;
    clip_cnt_d = clip_cnt_q;
    if (clear) begin
      clip_d     = 1'b0;
      clip_cnt_d = '0;
    end else if (clip_hit) begin
      clip_d     = 1'b1;
      clip_cnt_d = CLIP_LD;
    end else if (clip_cnt_q != '0) begin
      clip_cnt_d = clip_cnt_q - CLIP_CW'(1);
    end else begin
      clip_d = 1'b0;
    end
  end
`else
  // Clip thresholds have no function in this build; they are folded into
  // a dangling net so they do not read as forgotten parameters.
  logic unused_clip_cfg;
  assign unused_clip_cfg = ^{CLIP_LEVEL, CLIP_HOLD};
`endif

  // ---------------------------------------------------------------------
  // Bar display, computed from next-state peak so it lines up with peak.
  // ---------------------------------------------------------------------
  always_comb begin
    bar_d = 8'h00;
    for (int i = 0; i < 7; i++) begin
      bar_d[i] = (peak_d >= (16'd1 << (8 + i)));
    end
`ifdef PEAK_METER_CLIP_EN
    bar_d[7] = clip_d;
`else
    bar_d[7] = (peak_d >= 16'd32768);
`endif
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      peak_q     <= 16'd0;
      hold_cnt_q <= 16'd0;
      div_cnt_q  <= 16'd0;
      bar_q      <= 8'h00;
`ifdef PEAK_METER_CLIP_EN
      clip_q     <= 1'b0;
      clip_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bar_q      <= bar_d;
`ifdef PEAK_METER_CLIP_EN
      clip_q     <= clip_d;
      clip_cnt_q <= clip_cnt_d;
`endif
    end
  end

  assign peak = peak_q;
  assign bar  = bar_q;
`ifdef PEAK_METER_CLIP_EN
  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_peak_meter.sv
// Bench for peak_meter: two instances (short hold/decay and default
// parameters) share one stimulus stream and are compared every cycle
// against an age-based behavioural model, plus literal expectations.

module tb_peak_meter;

`ifdef PEAK_METER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic               clk_48   = 1'b0;
  logic               reset    = 1'b1;
  logic               clear    = 1'b0;
  logic signed [15:0] meter_in = 16'sd0;

  logic [15:0] peak_s, peak_d;
  logic [7:0]  bar_s, bar_d;
  logic        clip_s, clip_d;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  peak_meter #(
    .HOLD_SAMPLES(4), .DECAY_DIV(1), .DECAY_SHIFT(1),
    .CLIP_LEVEL(32767), .CLIP_HOLD(3)
  ) dut_s (
    .clk_48(clk_48), .reset(reset), .clear(clear), .meterIn(meter_in),
    .peak(peak_s), .bar(bar_s), .clip(clip_s)
  );

  peak_meter dut_d (
    .clk_48(clk_48), .reset(reset), .clear(clear), .meterIn(meter_in),
    .peak(peak_d), .bar(bar_d), .clip(clip_d)
  );

  always #5 clk_48 = ~clk_48;

  // ---------------------------------------------------------------------
  // Behavioural model: peak depends only on the last capture value and
  // the number of edges since it (age). Decay steps land at ages
  // HOLD + k*DIV, k >= 1. Clip is up while the age since the last
  // clipping sample is <= CLIP_HOLD.
  // ---------------------------------------------------------------------
  typedef struct packed {
    int peak;
    int age;
    int clip_age; // -1: no clip pending
  } mdl_t;

  mdl_t ms = '{peak: 0, age: 0, clip_age: -1};
  mdl_t md = '{peak: 0, age: 0, clip_age: -1};

  function automatic int absv(input logic signed [15:0] x);
    int v;
    v = int'(x);
    return (v < 0) ? -v : v;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int mag, input bit clr,
                                 input int hold, input int div, input int shift,
                                 input int clvl, input int chold);
    mdl_t n;
    int   s;
    n = m;
    if (clr) begin
      n.peak = 0; n.age = 0; n.clip_age = -1;
      return n;
    end
    if (mag != 0 && mag >= m.peak) begin
      n.peak = mag;
      n.age  = 0;
    end else if (m.peak != 0) begin
      n.age = m.age + 1;
      if (n.age > hold && ((n.age - hold) % div) == 0) begin
        s = (m.peak >> shift) | 1;
        n.peak = (s >= m.peak) ? 0 : m.peak - s;
      end
    end
    if (CLIP_EN) begin
      if (mag >= clvl) n.clip_age = 0;
      else if (m.clip_age >= 0 && m.clip_age < chold) n.clip_age = m.clip_age + 1;
      else n.clip_age = -1;
    end
    return n;
  endfunction

  function automatic logic [7:0] mbar(input int pk, input bit cl);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) b[i] = (pk >= (1 << (8 + i)));
    b[7] = CLIP_EN ? cl : (pk >= 32768);
    return b;
  endfunction

  always @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      ms = '{peak: 0, age: 0, clip_age: -1};
      md = '{peak: 0, age: 0, clip_age: -1};
    end else begin
      ms = mstep(ms, absv(meter_in), clear, 4, 1, 1, 32767, 3);
      md = mstep(md, absv(meter_in), clear, 24000, 48, 4, 32767, 48000);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk_48) begin
    if (chk_en) begin
      check("s_peak", peak_s, ms.peak);
      check("s_bar",  bar_s,  mbar(ms.peak, ms.clip_age >= 0));
      check("s_clip", clip_s, int'(ms.clip_age >= 0));
      check("d_peak", peak_d, md.peak);
      check("d_bar",  bar_d,  mbar(md.peak, md.clip_age >= 0));
      check("d_clip", clip_d, int'(md.clip_age >= 0));
    end
  end

  // Present a sample for one edge; return 2 time units after that edge.
  task automatic step(input int s, input bit c);
    meter_in = 16'(s);
    clear    = c;
    @(posedge clk_48);
    #2;
  endtask

  function automatic int sine(input int amp, input int n);
    real v;
    v = amp * $sin(2.0 * 3.14159265358979 * n / 48.0);
    return $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  int seq1 [20] = '{16384, 16384, 16384, 16384, 16384, 8191, 4096, 2047, 1024,
                    511, 256, 127, 64, 31, 16, 7, 4, 1, 0, 0};
  int s, kind, len, pick, cnt, k;
  bit c;

  initial begin
    #12;
    chk_en = 1'b1;
    check("rst_peak", peak_s, 0);
    check("rst_bar",  bar_s,  0);
    check("rst_clip", clip_s, 0);
    check("rst_peak_d", peak_d, 0);
    @(posedge clk_48); #2;
    reset = 1'b0;

    // Single sample then zeros: hold then halving decay.
    step(0, 1'b1);
    step(16384, 1'b0);
    check("s1_bar_full", bar_s, 8'h7F);
    check("s1_peak_0", peak_s, seq1[0]);
    for (int i = 1; i < 20; i++) begin
      step(0, 1'b0);
      check("s1_peak_seq", peak_s, seq1[i]);
      if (i == 5) check("s1_bar_8191", bar_s, 8'h1F);
    end

    // Full negative scale and clip thresholds.
    step(0, 1'b1);
    step(-32768, 1'b0);
    check("s2_peak", peak_s, 32768);
    check("s2_bar7", bar_s[7], 1);
    check("s2_clip0", clip_s, int'(CLIP_EN));
    for (int i = 1; i < 6; i++) begin
      step(0, 1'b0);
      check("s2_clip_seq", clip_s, int'(CLIP_EN && i < 4));
    end
    step(0, 1'b1);
    step(32767, 1'b0);
    check("s2_clip_32767", clip_s, int'(CLIP_EN));
    step(0, 1'b1);
    step(32766, 1'b0);
    check("s2_clip_32766", clip_s, 0);
    check("s2_peak_32766", peak_s, 32766);
    check("s2_bar_32766", bar_s, 8'h7F);

    // Larger sample during decay recaptures and reloads the hold.
    step(0, 1'b1);
    step(5000, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0);
    check("s5_decaying", peak_s, 1250);
    step(6000, 1'b0);
    check("s5_recap", peak_s, 6000);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b0);
      check("s5_hold", peak_s, 6000);
    end
    step(0, 1'b0);
    check("s5_step", peak_s, 2999);

    // Clear during hold discards the concurrent sample.
    step(0, 1'b1);
    step(20000, 1'b0);
    step(0, 1'b0);
    step(32767, 1'b1);
    check("s6_clr_peak", peak_s, 0);
    check("s6_clr_bar",  bar_s,  0);
    check("s6_clr_clip", clip_s, 0);
    check("s6_clr_peak_d", peak_d, 0);

    // Randomised bursts of mixed amplitudes with sporadic clears.
    for (int b = 0; b < 120; b++) begin
      kind = int'($urandom_range(0, 5));
      len  = int'($urandom_range(1, 30));
      for (int j = 0; j < len; j++) begin
        c = ($urandom_range(0, 99) == 0);
        case (kind)
          0, 1: s = 0;
          2: s = int'($urandom_range(0, 600)) - 300;
          3: s = int'($urandom_range(0, 40000)) - 20000;
          4: begin
            pick = int'($urandom_range(0, 3));
            s = (pick == 0) ? 32767 : (pick == 1) ? -32768 : (pick == 2) ? 32766 : -32767;
          end
          default: s = int'($urandom_range(0, 65535)) - 32768;
        endcase
        step(s, c);
      end
    end

    // Full-scale sine at default parameters: peak pinned, no decay.
    step(0, 1'b1);
    for (int n = 0; n < 144; n++) step(sine(32767, n), 1'b0);
    check("s3_peak", peak_d, 32767);
    check("s3_clip", clip_d, int'(CLIP_EN));
    check("s3_bar", bar_d, CLIP_EN ? 8'hFF : 8'h7F);

    // Sine of 16383 muted at 1.5 ms: long hold, then stepped decay.
    step(0, 1'b1);
    for (int n = 0; n <= 60; n++) step(sine(16383, n), 1'b0);
    check("s4_peak", peak_d, 16383);
    cnt = 0;
    k = 61;
    while (peak_d == 16'd16383 && cnt < 30000) begin
      cnt++;
      step((k < 72) ? sine(16383, k) : 0, 1'b0);
      k++;
    end
    check("s4_hold_len", cnt, 24048);
    check("s4_first_step", peak_d, 15360);
    cnt = 0;
    while (peak_d != 16'd0 && cnt < 20000) begin
      cnt++;
      step(0, 1'b0);
    end
    check("s4_reach_zero", peak_d, 0);
    check("s4_bar_zero", bar_d, 0);

    // Asynchronous reset mid-decay clears outputs before the next edge.
    step(0, 1'b1);
    step(20000, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0);
    reset = 1'b1;
    #1;
    check("s6_rst_peak", peak_s, 0);
    check("s6_rst_bar",  bar_s,  0);
    check("s6_rst_clip", clip_s, 0);
    check("s6_rst_peak_d", peak_d, 0);
    check("s6_rst_bar_d",  bar_d,  0);
    @(posedge clk_48); #2;
    reset = 1'b0;
    step(0, 1'b0);
    check("s6_post_rst", peak_s, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
